// File: rtl/bubsysrom_sram_arbiter.sv
// Single-port SRAM access controller: clear engine, video fetch and CPU
// clients share one registered SRAM command port. Read returns are routed
// back through a two-stage tag pipeline that matches the SRAM read latency.
//
//   state        | meaning
//   CPU_IDLE     | no CPU access outstanding
//   CPU_WAIT     | request seen, slot taken by clear or video
//   CPU_INFLIGHT | CPU read issued, data not yet returned
//   CPU_ACK      | ack cycle; request sampled here is ignored
module bubsysrom_sram_arbiter #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          i_MCLK,
    input  logic          i_RST_n,
    input  logic          i_CPU_REQ,
    input  logic          i_CPU_WE,
    input  logic [AW-1:0] i_CPU_ADDR,
    input  logic [DW-1:0] i_CPU_DIN,
    output logic          o_CPU_ACK,
    output logic [DW-1:0] o_CPU_DOUT,
    input  logic          i_VID_REQ,
    input  logic [AW-1:0] i_VID_ADDR,
    output logic          o_VID_VALID,
    output logic [DW-1:0] o_VID_DOUT,
    input  logic          i_CLR_START,
    output logic          o_CLR_BUSY,
    output logic [AW-1:0] o_SRAM_ADDR,
    output logic [DW-1:0] o_SRAM_DIN,
    output logic          o_SRAM_RD,
    output logic          o_SRAM_WR,
    input  logic [DW-1:0] i_SRAM_DOUT
);

    typedef enum logic [1:0] {
        CPU_IDLE,
        CPU_WAIT,
        CPU_INFLIGHT,
        CPU_ACK
    } cpu_state_t;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_VID,
        TAG_CPU
    } tag_t;

    cpu_state_t    cpu_state;
    cpu_state_t    cpu_state_nx;
    tag_t          tag_s1;
    tag_t          tag_s2;
    logic [AW-1:0] clr_cnt;
    logic          clr_take;
    logic          vid_go;
    logic          cpu_free;
    logic          cpu_grant;

    // Slot arbitration. The clear owns the slot from the accepted start edge
    // until the counter wraps back to zero; the wrap edge itself is free.
    always_comb begin
        clr_take     = (i_CLR_START && !o_CLR_BUSY) || (o_CLR_BUSY && (clr_cnt != '0));
        vid_go       = i_VID_REQ && !clr_take;
        cpu_free     = !clr_take && !vid_go;
        cpu_grant    = 1'b0;
        cpu_state_nx = cpu_state;
        case (cpu_state)
            CPU_IDLE: begin
                if (i_CPU_REQ) begin
                    if (cpu_free) begin
                        cpu_grant    = 1'b1;
                        cpu_state_nx = i_CPU_WE ? CPU_ACK : CPU_INFLIGHT;
                    end else begin
                        cpu_state_nx = CPU_WAIT;
                    end
                end
            end
            CPU_WAIT: begin
                if (cpu_free) begin
                    cpu_grant    = 1'b1;
                    cpu_state_nx = i_CPU_WE ? CPU_ACK : CPU_INFLIGHT;
                end
            end
            CPU_INFLIGHT: begin
                if (tag_s2 == TAG_CPU) cpu_state_nx = CPU_ACK;
            end
            CPU_ACK: begin
                cpu_state_nx = CPU_IDLE;
            end
            default: cpu_state_nx = CPU_IDLE;
        endcase
    end

    // CPU FSM state register.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) cpu_state <= CPU_IDLE;
        else          cpu_state <= cpu_state_nx;
    end

    // Clear engine and registered SRAM command pins (one command per cycle).
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            clr_cnt     <= '0;
            o_CLR_BUSY  <= 1'b0;
            o_SRAM_ADDR <= '0;
            o_SRAM_DIN  <= '0;
            o_SRAM_RD   <= 1'b0;
            o_SRAM_WR   <= 1'b0;
        end else begin
            o_SRAM_RD <= 1'b0;
            o_SRAM_WR <= 1'b0;
            if (clr_take) begin
                o_CLR_BUSY  <= 1'b1;
                o_SRAM_WR   <= 1'b1;
                o_SRAM_ADDR <= clr_cnt;
                o_SRAM_DIN  <= '0;
                clr_cnt     <= clr_cnt + 1'b1;
            end else begin
                o_CLR_BUSY <= 1'b0;
                if (vid_go) begin
                    o_SRAM_RD   <= 1'b1;
                    o_SRAM_ADDR <= i_VID_ADDR;
                end else if (cpu_grant) begin
                    o_SRAM_ADDR <= i_CPU_ADDR;
                    if (i_CPU_WE) begin
                        o_SRAM_WR  <= 1'b1;
                        o_SRAM_DIN <= i_CPU_DIN;
                    end else begin
                        o_SRAM_RD <= 1'b1;
                    end
                end
            end
        end
    end

    // Read tag pipeline and return path; writes ack on the grant edge.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            tag_s1      <= TAG_NONE;
            tag_s2      <= TAG_NONE;
            o_CPU_ACK   <= 1'b0;
            o_CPU_DOUT  <= '0;
            o_VID_VALID <= 1'b0;
            o_VID_DOUT  <= '0;
        end else begin
            if (vid_go)                      tag_s1 <= TAG_VID;
            else if (cpu_grant && !i_CPU_WE) tag_s1 <= TAG_CPU;
            else                             tag_s1 <= TAG_NONE;
            tag_s2      <= tag_s1;
            o_CPU_ACK   <= (cpu_grant && i_CPU_WE) || (tag_s2 == TAG_CPU);
            o_VID_VALID <= (tag_s2 == TAG_VID);
            if (tag_s2 == TAG_CPU) o_CPU_DOUT <= i_SRAM_DOUT;
            if (tag_s2 == TAG_VID) o_VID_DOUT <= i_SRAM_DOUT;
        end
    end

endmodule
